// File: rtl/dual_b_multiplier.sv
// Dual-register B operand path feeding a signed 25x18 multiplier with an optional M register.
// Supplies M to the X/Y mux and ALU, B2 to the X mux, and a B cascade to the next slice.
module dual_b_multiplier #(
  parameter string B_INPUT  = "DIRECT",
  parameter int    BREG     = 2,
  parameter int    BCASCREG = 1,
  parameter int    MREG     = 1,
  parameter string USE_MULT = "MULTIPLY"
) (
  input  logic        CLK,
  input  logic        RSTB,
  input  logic        RSTM,
  input  logic [17:0] B,
  input  logic [17:0] BCIN,
  input  logic [24:0] A_MULT,
  input  logic        INMODE_4,
  input  logic        CEB1,
  input  logic        CEB2,
  input  logic        CEM,
  output logic [17:0] BCOUT,
  output logic [17:0] X_MUX_B,
  output logic [42:0] M
);

  localparam bit LEGAL_B = (BREG == 2 && (BCASCREG == 1 || BCASCREG == 2)) ||
                           (BREG == 1 && BCASCREG == 1) ||
                           (BREG == 0 && BCASCREG == 0);
  localparam bit LEGAL_M = (MREG == 0 || MREG == 1) &&
                           (USE_MULT == "MULTIPLY" || USE_MULT == "NONE") &&
                           (B_INPUT == "DIRECT" || B_INPUT == "CASCADE");

  generate
    if (!(LEGAL_B && LEGAL_M)) begin : g_illegal_params
      $error("dual_b_multiplier: illegal BREG/BCASCREG/MREG/B_INPUT/USE_MULT combination");
    end
  endgenerate

  logic [17:0]        b1_in;
  logic [17:0]        b1;
  logic [17:0]        b2;
  logic [17:0]        b_mult;
  logic signed [42:0] a_ext;
  logic signed [42:0] b_ext;
  logic signed [42:0] product;

  assign b1_in = (B_INPUT == "CASCADE") ? BCIN : B;

  generate
    if (BREG == 2) begin : g_breg2
      logic [17:0] b1_q;
      logic [17:0] b2_q;
      // NOTE: non-blocking assignments let B2 capture the old B1 on the same edge B1 reloads.
      always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB) begin
          b1_q <= '0;
          b2_q <= '0;
        end else begin
          if (CEB1) b1_q <= b1_in;
          if (CEB2) b2_q <= b1_q;
        end
      end
      assign b1 = b1_q;
      assign b2 = b2_q;
    end else if (BREG == 1) begin : g_breg1
      logic [17:0] b1_q;
      always_ff @(posedge CLK or posedge RSTB) begin
        if (RSTB)      b1_q <= '0;
        else if (CEB1) b1_q <= b1_in;
      end
      assign b1 = b1_q;
      assign b2 = b1_q;
    end else begin : g_breg0
      assign b1 = b1_in;
      assign b2 = b1_in;
    end
  endgenerate

  assign X_MUX_B = b2;

  generate
    if (BCASCREG == 2) begin : g_bcas2
      assign BCOUT = b2;
    end else if (BCASCREG == 1) begin : g_bcas1
      assign BCOUT = b1;
    end else begin : g_bcas0
      assign BCOUT = b1_in;
    end
  endgenerate

  assign b_mult = INMODE_4 ? b1 : b2;

  // Both operands widened to the full product width so the signed multiply never truncates.
  assign a_ext   = $signed({{18{A_MULT[24]}}, A_MULT});
  assign b_ext   = $signed({{25{b_mult[17]}}, b_mult});
  assign product = a_ext * b_ext;

  generate
    if (USE_MULT == "NONE") begin : g_no_mult
      assign M = '0;
    end else if (MREG == 1) begin : g_mreg
      logic [42:0] m_r;
      always_ff @(posedge CLK or posedge RSTM) begin
        if (RSTM)     m_r <= '0;
        else if (CEM) m_r <= product;
      end
      assign M = m_r;
    end else begin : g_mcomb
      assign M = product;
    end
  endgenerate

  // Several parameter sets leave some of these inputs unread.
  logic unused_ok;
  assign unused_ok = ^{CLK, RSTB, RSTM, B, BCIN, A_MULT, INMODE_4, CEB1, CEB2, CEM, product};

endmodule

// File: tb/tb_dual_b_multiplier.sv
// Scoreboard bench for dual_b_multiplier: stimulus queues expected values with a due cycle,
// a negedge monitor pops and compares them against four differently configured instances.
module tb_dual_b_multiplier;

  typedef enum int {S_M, S_BCOUT, S_XB, S_M_CASC, S_M_COMB, S_M_NONE} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [42:0] exp;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic        clk = 1'b0;
  logic        rstb, rstm, inmode, ceb1, ceb2, cem;
  logic [17:0] b, bcin;
  logic [24:0] a;

  logic [17:0] bcout, xb, bcout_c, xb_c, bcout_k, xb_k, bcout_n, xb_n;
  logic [42:0] m, m_c, m_k, m_n;

  dual_b_multiplier dut (
    .CLK(clk), .RSTB(rstb), .RSTM(rstm), .B(b), .BCIN(bcin), .A_MULT(a),
    .INMODE_4(inmode), .CEB1(ceb1), .CEB2(ceb2), .CEM(cem),
    .BCOUT(bcout), .X_MUX_B(xb), .M(m)
  );

  dual_b_multiplier #(.B_INPUT("CASCADE")) dut_casc (
    .CLK(clk), .RSTB(rstb), .RSTM(rstm), .B(b), .BCIN(bcin), .A_MULT(a),
    .INMODE_4(inmode), .CEB1(ceb1), .CEB2(ceb2), .CEM(cem),
    .BCOUT(bcout_c), .X_MUX_B(xb_c), .M(m_c)
  );

  dual_b_multiplier #(.BREG(0), .BCASCREG(0), .MREG(0)) dut_comb (
    .CLK(clk), .RSTB(rstb), .RSTM(rstm), .B(b), .BCIN(bcin), .A_MULT(a),
    .INMODE_4(inmode), .CEB1(ceb1), .CEB2(ceb2), .CEM(cem),
    .BCOUT(bcout_k), .X_MUX_B(xb_k), .M(m_k)
  );

  dual_b_multiplier #(.USE_MULT("NONE")) dut_none (
    .CLK(clk), .RSTB(rstb), .RSTM(rstm), .B(b), .BCIN(bcin), .A_MULT(a),
    .INMODE_4(inmode), .CEB1(ceb1), .CEB2(ceb2), .CEM(cem),
    .BCOUT(bcout_n), .X_MUX_B(xb_n), .M(m_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [42:0] actual(input sig_e s);
    case (s)
      S_M:      return m;
      S_BCOUT:  return {25'd0, bcout};
      S_XB:     return {25'd0, xb};
      S_M_CASC: return m_c;
      S_M_COMB: return m_k;
      S_M_NONE: return m_n;
      default:  return 'x;
    endcase
  endfunction

  task automatic push(input string name, input sig_e s, input logic [42:0] v, input int d);
    exp_t e;
    e.name = name;
    e.sig  = s;
    e.exp  = v;
    e.due  = cyc + d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every negedge, compare and retire all entries due by this cycle.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      idx = 0;
      while (idx < sb.size()) begin
        if (sb[idx].due <= cyc) begin
          check(sb[idx].name, actual(sb[idx].sig), sb[idx].exp);
          sb.delete(idx);
        end else begin
          idx++;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    rstb = 1'b1; rstm = 1'b1; inmode = 1'b0;
    ceb1 = 1'b1; ceb2 = 1'b1; cem = 1'b1;
    b = 18'd9; bcin = 18'd0; a = 25'd3;
    step(); step();
    // Resets held with all CEs high and nonzero operands: everything stays 0.
    push("rst_m",     S_M,      43'd0, 0);
    push("rst_bcout", S_BCOUT,  43'd0, 0);
    push("rst_xb",    S_XB,     43'd0, 0);
    push("rst_m_casc",S_M_CASC, 43'd0, 0);
    step();
    rstb = 1'b0; rstm = 1'b0; b = 18'd0; a = 25'd0;
    step();

    // Basic latency: 3*5 through BREG=2, MREG=1.
    a = 25'd3; b = 18'd5;
    push("lat_bcout",  S_BCOUT,  43'd5,  1);
    push("lat_xb",     S_XB,     43'd5,  2);
    push("lat_m_early",S_M,      43'd0,  2);
    push("lat_m",      S_M,      43'd15, 3);
    push("comb_basic", S_M_COMB, 43'd15, 0);
    push("none_basic", S_M_NONE, 43'd0,  0);
    push("casc_sel",   S_M_CASC, 43'd0,  3);
    step(); step(); step();

    // Signed extremes.
    a = 25'h100_0000; b = 18'h2_0000;
    push("ext_negneg",      S_M,      43'h200_0000_0000, 3);
    push("comb_ext_negneg", S_M_COMB, 43'h200_0000_0000, 0);
    push("none_ext",        S_M_NONE, 43'd0,             0);
    step(); step(); step();
    a = 25'h0FF_FFFF;
    push("ext_posneg",      S_M,      43'h600_0002_0000, 1);
    push("comb_ext_posneg", S_M_COMB, 43'h600_0002_0000, 0);
    step();

    // INMODE_4 select: B1=7, B2 held at 2.
    a = 25'd10; b = 18'd2;
    step(); step();
    b = 18'd7; ceb2 = 1'b0;
    step();
    inmode = 1'b1;
    push("sel_bcout_b1", S_BCOUT, 43'd7,  0);
    push("sel_xb_hold",  S_XB,    43'd2,  0);
    push("sel_b1",       S_M,     43'd70, 1);
    step();
    inmode = 1'b0;
    push("sel_b2",       S_M,     43'd20, 1);
    push("sel_xb_hold2", S_XB,    43'd2,  1);
    step();

    // CEM hold, then one enabled edge.
    cem = 1'b0; a = 25'd3; inmode = 1'b1;
    push("cem_hold1", S_M, 43'd20, 1);
    push("cem_hold2", S_M, 43'd20, 2);
    step(); step();
    cem = 1'b1;
    push("cem_once", S_M, 43'd21, 1);
    step();
    cem = 1'b0; a = 25'd5;
    push("cem_hold3", S_M, 43'd21, 1);
    push("cem_hold4", S_M, 43'd21, 2);
    step(); step();

    // Asynchronous resets mid-stream.
    cem = 1'b1; inmode = 1'b0; ceb2 = 1'b1; a = 25'd3; b = 18'd5;
    push("pre_rst_m", S_M, 43'd15, 3);
    step(); step(); step();
    step();
    push("rstm_async", S_M, 43'd0, 0);
    #1 rstm = 1'b1;
    #1 rstm = 1'b0;
    step();
    push("rstb_m_keep",  S_M,     43'd15, 0);
    push("rstb_bcout",   S_BCOUT, 43'd0,  0);
    push("rstb_xb",      S_XB,    43'd0,  0);
    push("rstb_m_next",  S_M,     43'd0,  1);
    push("rstb_bcout_r", S_BCOUT, 43'd5,  1);
    push("rstb_xb_next", S_XB,    43'd0,  1);
    #1 rstb = 1'b1;
    #1 rstb = 1'b0;
    step();

    // Configuration sweep.
    bcin = 18'h3_FFFF; a = 25'd4; b = 18'h3_FFFD;
    push("casc_m",     S_M_CASC, 43'h7FF_FFFF_FFFC, 3);
    push("comb_neg",   S_M_COMB, 43'h7FF_FFFF_FFF4, 0);
    push("none_neg",   S_M_NONE, 43'd0,             0);
    step(); step(); step();
    a = 25'h1FF_FFFF; b = 18'h1_FFFF;
    push("comb_mixed", S_M_COMB, 43'h7FF_FFFE_0001, 0);
    push("none_mixed", S_M_NONE, 43'd0,             0);
    step();

    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    if (sb.size() != 0) begin
      $display("FAIL drain: %0d expectations never compared, required 0", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
